sram_axi_slave: RTL and testbench

AXI-style slave that services the single-word read and write transactions produced by the UART debug bridge and executes them against an external 256K×16 asynchronous SRAM. It sits directly downstream of the bridge's AR/R/AW/W/B channels. It drives the SRAM address, data and control pins with programmable access wait states. Only one transaction is in flight at a time, and there are no bursts, strobes or response codes.

---
 rtl/sram_axi_slave_if.sv | 40 ++++
 rtl/sram_axi_slave.sv | 189 ++++++++++++++++++
 tb/tb_sram_axi_slave.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_slave_if.sv
// ---------------------------------------------------------------------------
// sram_axi_slave_if
// Single-word AXI-style channel bundle between the UART debug bridge (master)
// and the SRAM slave.
//   AR : axi_ar_addr[17:0], axi_ar_valid, axi_ar_ready
//   R  : axi_r_data[15:0],  axi_r_valid,  axi_r_ready
//   AW : axi_aw_addr[17:0], axi_aw_valid, axi_aw_ready
//   W  : axi_w_data[15:0],  axi_w_valid,  axi_w_ready
//   B  : axi_b_valid, axi_b_ready
// ---------------------------------------------------------------------------
interface sram_axi_slave_if;
    logic [17:0] axi_ar_addr;
    logic        axi_ar_valid;
    logic        axi_ar_ready;
    logic [15:0] axi_r_data;
    logic        axi_r_valid;
    logic        axi_r_ready;
    logic [17:0] axi_aw_addr;
    logic        axi_aw_valid;
    logic        axi_aw_ready;
    logic [15:0] axi_w_data;
    logic        axi_w_valid;
    logic        axi_w_ready;
    logic        axi_b_valid;
    logic        axi_b_ready;

    modport master (
        output axi_ar_addr, axi_ar_valid, axi_r_ready,
        output axi_aw_addr, axi_aw_valid, axi_w_data, axi_w_valid, axi_b_ready,
        input  axi_ar_ready, axi_r_data, axi_r_valid,
        input  axi_aw_ready, axi_w_ready, axi_b_valid
    );

    modport slave (
        input  axi_ar_addr, axi_ar_valid, axi_r_ready,
        input  axi_aw_addr, axi_aw_valid, axi_w_data, axi_w_valid, axi_b_ready,
        output axi_ar_ready, axi_r_data, axi_r_valid,
        output axi_aw_ready, axi_w_ready, axi_b_valid
    );
endinterface

// File: rtl/sram_axi_slave.sv
// ---------------------------------------------------------------------------
// sram_axi_slave
// Services one single-word read or write at a time from the debug bridge and
// runs it against a 256Kx16 asynchronous SRAM with programmable wait states.
//   clk, rst_n      : system clock, async active-low reset
//   axi             : AR/R/AW/W/B channel bundle (slave side)
//   sram_addr       : SRAM word address
//   sram_dq_o/_oe   : write data and its tristate enable
//   sram_dq_i       : read data from the pad
//   sram_*_n        : active-low SRAM controls (all registered)
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for AR, AW or W
// RD_ACC     | setup cycle, then ce/oe low for RD_WAIT cycles, sample data
// RD_RESP    | r_valid held until r_ready
// WR_COLLECT | one write half captured, waiting for the other
// WR_SETUP   | address/data driven, we_n still high (1 cycle)
// WR_PULSE   | we_n low for WR_WAIT cycles
// WR_HOLD    | we_n high, address/data still driven (1 cycle)
// WR_RESP    | b_valid held until b_ready
// ---------------------------------------------------------------------------
module sram_axi_slave #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sram_axi_slave_if.slave        axi,
    output logic [17:0]            sram_addr,
    output logic [15:0]            sram_dq_o,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_i,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_lb_n,
    output logic                   sram_ub_n
);
    typedef enum logic [2:0] {
        IDLE, RD_ACC, RD_RESP, WR_COLLECT, WR_SETUP, WR_PULSE, WR_HOLD, WR_RESP
    } state_t;

    localparam logic [7:0] RD_LOAD = 8'(RD_WAIT - 1);
    localparam logic [7:0] WR_LOAD = 8'(WR_WAIT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_aw_cap;
    logic        r_w_cap;
    logic [15:0] r_r_data;
    logic        r_r_valid;
    logic        r_b_valid;
    logic [17:0] r_addr;
    logic [15:0] r_dq_o;
    logic        r_dq_oe;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;

    logic w_idle;
    logic w_collect;
    logic w_ar_rdy;
    logic w_aw_rdy;
    logic w_w_rdy;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_cap_nxt;
    logic w_w_cap_nxt;

    // Readies come from registered state only; rst_n gating keeps them low
    // while the block is held in reset.
    assign w_idle       = (r_state == IDLE);
    assign w_collect    = (r_state == WR_COLLECT);
    assign w_ar_rdy     = rst_n & w_idle;
    assign w_aw_rdy     = rst_n & (w_idle | w_collect) & ~r_aw_cap;
    assign w_w_rdy      = rst_n & (w_idle | w_collect) & ~r_w_cap;
    assign w_aw_hs      = w_aw_rdy & axi.axi_aw_valid;
    assign w_w_hs       = w_w_rdy & axi.axi_w_valid;
    assign w_aw_cap_nxt = r_aw_cap | w_aw_hs;
    assign w_w_cap_nxt  = r_w_cap | w_w_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_aw_cap  <= 1'b0;
            r_w_cap   <= 1'b0;
            r_r_data  <= 16'd0;
            r_r_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_addr    <= 18'd0;
            r_dq_o    <= 16'd0;
            r_dq_oe   <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
        end else begin
            case (r_state)
                IDLE, WR_COLLECT: begin
                    // A read in IDLE wins; any same-cycle AW/W handshake is dropped.
                    if (w_ar_rdy && axi.axi_ar_valid) begin
                        r_addr  <= axi.axi_ar_addr;
                        r_cnt   <= RD_LOAD;
                        r_state <= RD_ACC;
                    end else begin
                        if (w_aw_hs) r_addr <= axi.axi_aw_addr;
                        if (w_w_hs)  r_dq_o <= axi.axi_w_data;
                        r_aw_cap <= w_aw_cap_nxt;
                        r_w_cap  <= w_w_cap_nxt;
                        if (w_aw_cap_nxt && w_w_cap_nxt) begin
                            r_dq_oe <= 1'b1;
                            r_ce_n  <= 1'b0;
                            r_state <= WR_SETUP;
                        end else if (w_aw_cap_nxt || w_w_cap_nxt) begin
                            r_state <= WR_COLLECT;
                        end
                    end
                end
                RD_ACC: begin
                    // oe_n is still high only on the address setup cycle.
                    if (r_oe_n) begin
                        r_ce_n <= 1'b0;
                        r_oe_n <= 1'b0;
                    end else if (r_cnt == 8'd0) begin
                        r_r_data  <= sram_dq_i;
                        r_r_valid <= 1'b1;
                        r_ce_n    <= 1'b1;
                        r_oe_n    <= 1'b1;
                        r_state   <= RD_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                RD_RESP: begin
                    if (axi.axi_r_ready) begin
                        r_r_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_cnt   <= WR_LOAD;
                    r_state <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (r_cnt == 8'd0) begin
                        r_we_n  <= 1'b1;
                        r_state <= WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                WR_HOLD: begin
                    r_ce_n    <= 1'b1;
                    r_dq_oe   <= 1'b0;
                    r_aw_cap  <= 1'b0;
                    r_w_cap   <= 1'b0;
                    r_b_valid <= 1'b1;
                    r_state   <= WR_RESP;
                end
                WR_RESP: begin
                    if (axi.axi_b_ready) begin
                        r_b_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign axi.axi_ar_ready = w_ar_rdy;
    assign axi.axi_aw_ready = w_aw_rdy;
    assign axi.axi_w_ready  = w_w_rdy;
    assign axi.axi_r_data   = r_r_data;
    assign axi.axi_r_valid  = r_r_valid;
    assign axi.axi_b_valid  = r_b_valid;

    // Full-word accesses only: both byte lanes follow chip enable.
    assign sram_addr  = r_addr;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign sram_lb_n  = r_ce_n;
    assign sram_ub_n  = r_ce_n;
endmodule

// File: tb/tb_sram_axi_slave.sv
// ---------------------------------------------------------------------------
// tb_sram_axi_slave
// Two instances: dut0 (RD_WAIT=2, WR_WAIT=2) and dut1 (RD_WAIT=1, WR_WAIT=5).
// 'sel' routes the shared stimulus to one of them and muxes its outputs to
// the monitor. Expected responses are queued when a transaction is issued and
// popped by the monitor when r_valid / b_valid rise.
// ---------------------------------------------------------------------------
module tb_sram_axi_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    bit   sel = 1'b0;

    logic [17:0] ar_addr = '0, aw_addr = '0;
    logic [15:0] w_data = '0;
    logic ar_valid = 1'b0, aw_valid = 1'b0, w_valid = 1'b0;
    logic r_ready = 1'b0, b_ready = 1'b0;

    logic [17:0] s_addr [2];
    logic [15:0] s_dqo  [2];
    logic [15:0] s_dqi  [2];
    logic s_dqoe [2];
    logic s_ce [2];
    logic s_oe [2];
    logic s_we [2];
    logic s_lb [2];
    logic s_ub [2];

    sram_axi_slave_if if0();
    sram_axi_slave_if if1();

    assign if0.axi_ar_addr  = ar_addr;
    assign if0.axi_ar_valid = ar_valid & ~sel;
    assign if0.axi_r_ready  = r_ready & ~sel;
    assign if0.axi_aw_addr  = aw_addr;
    assign if0.axi_aw_valid = aw_valid & ~sel;
    assign if0.axi_w_data   = w_data;
    assign if0.axi_w_valid  = w_valid & ~sel;
    assign if0.axi_b_ready  = b_ready & ~sel;

    assign if1.axi_ar_addr  = ar_addr;
    assign if1.axi_ar_valid = ar_valid & sel;
    assign if1.axi_r_ready  = r_ready & sel;
    assign if1.axi_aw_addr  = aw_addr;
    assign if1.axi_aw_valid = aw_valid & sel;
    assign if1.axi_w_data   = w_data;
    assign if1.axi_w_valid  = w_valid & sel;
    assign if1.axi_b_ready  = b_ready & sel;

    sram_axi_slave #(.RD_WAIT(2), .WR_WAIT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .axi(if0),
        .sram_addr(s_addr[0]), .sram_dq_o(s_dqo[0]), .sram_dq_oe(s_dqoe[0]),
        .sram_dq_i(s_dqi[0]), .sram_ce_n(s_ce[0]), .sram_oe_n(s_oe[0]),
        .sram_we_n(s_we[0]), .sram_lb_n(s_lb[0]), .sram_ub_n(s_ub[0])
    );

    sram_axi_slave #(.RD_WAIT(1), .WR_WAIT(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .axi(if1),
        .sram_addr(s_addr[1]), .sram_dq_o(s_dqo[1]), .sram_dq_oe(s_dqoe[1]),
        .sram_dq_i(s_dqi[1]), .sram_ce_n(s_ce[1]), .sram_oe_n(s_oe[1]),
        .sram_we_n(s_we[1]), .sram_lb_n(s_lb[1]), .sram_ub_n(s_ub[1])
    );

    // Behavioural asynchronous SRAMs (one per DUT) and the reference memory.
    logic [15:0] mem     [0:1][0:262143];
    logic [15:0] ref_mem [0:1][0:262143];

    function automatic logic [15:0] dflt(input logic [17:0] a);
        return a[15:0] ^ {6'h2D, a[17:8]};
    endfunction

    assign s_dqi[0] = (!s_ce[0] && !s_oe[0] && !s_lb[0] && !s_ub[0]) ? mem[0][s_addr[0]] : 16'hDEAD;
    assign s_dqi[1] = (!s_ce[1] && !s_oe[1] && !s_lb[1] && !s_ub[1]) ? mem[1][s_addr[1]] : 16'hDEAD;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (!s_ce[k] && !s_we[k] && !s_lb[k] && !s_ub[k]) mem[k][s_addr[k]] = s_dqo[k];
    end

    // Muxed view of the selected DUT.
    logic m_ar_ready, m_aw_ready, m_w_ready, m_r_valid, m_b_valid;
    logic [15:0] m_r_data, m_dqo;
    logic [17:0] m_addr;
    logic m_dqoe, m_ce_n, m_oe_n, m_we_n;
    always_comb begin
        m_ar_ready = sel ? if1.axi_ar_ready : if0.axi_ar_ready;
        m_aw_ready = sel ? if1.axi_aw_ready : if0.axi_aw_ready;
        m_w_ready  = sel ? if1.axi_w_ready  : if0.axi_w_ready;
        m_r_valid  = sel ? if1.axi_r_valid  : if0.axi_r_valid;
        m_b_valid  = sel ? if1.axi_b_valid  : if0.axi_b_valid;
        m_r_data   = sel ? if1.axi_r_data   : if0.axi_r_data;
        m_addr     = s_addr[sel];
        m_dqo      = s_dqo[sel];
        m_dqoe     = s_dqoe[sel];
        m_ce_n     = s_ce[sel];
        m_oe_n     = s_oe[sel];
        m_we_n     = s_we[sel];
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h want %0h (dut%0d t=%0t)", name, act, exp, sel, $time);
    endtask

    function automatic int rd_wait();
        return sel ? 1 : 2;
    endfunction
    function automatic int wr_wait();
        return sel ? 5 : 2;
    endfunction

    typedef struct { logic [15:0] data; time t; } rexp_t;
    typedef struct { logic [17:0] addr; logic [15:0] data; time t; } wexp_t;
    rexp_t exp_r[$];
    wexp_t exp_w[$];

    // ------------------------------------------------------------ monitor
    bit r_hs_d, b_hs_d;
    always @(posedge clk) begin
        r_hs_d = m_r_valid && r_ready && rst_n;
        b_hs_d = m_b_valid && b_ready && rst_n;
    end

    rexp_t cur_r;
    bit prev_rv = 0, prev_bv = 0, prev_oe_n = 1, prev_we_n = 1;
    int oe_cnt = 0, we_cnt = 0, lat;

    always @(negedge clk) begin
        chk(!(!m_oe_n && m_dqoe), "bus_oe_with_dq_oe", {30'd0, m_oe_n, m_dqoe}, 32'h2);
        chk(m_we_n || (m_dqoe && !m_ce_n && m_oe_n), "we_outside_write", {29'd0, m_we_n, m_dqoe, m_ce_n}, 32'h2);
        if (!rst_n) begin
            oe_cnt = 0; we_cnt = 0; prev_oe_n = 1; prev_we_n = 1; prev_rv = 0; prev_bv = 0;
        end else begin
            if (!m_oe_n) oe_cnt++;
            else if (!prev_oe_n) begin
                chk(oe_cnt == rd_wait(), "oe_low_cycles", oe_cnt, rd_wait());
                oe_cnt = 0;
            end
            prev_oe_n = m_oe_n;
            if (!m_we_n) we_cnt++;
            else if (!prev_we_n) begin
                chk(we_cnt == wr_wait(), "we_low_cycles", we_cnt, wr_wait());
                we_cnt = 0;
            end
            prev_we_n = m_we_n;

            if (m_dqoe) begin
                if (exp_w.size() == 0) chk(0, "write_drive_unexpected", {14'd0, m_addr}, 0);
                else chk(m_addr == exp_w[0].addr && m_dqo == exp_w[0].data, "write_addr_data",
                         {m_addr[15:0], m_dqo}, {exp_w[0].addr[15:0], exp_w[0].data});
            end

            if (m_r_valid && !prev_rv) begin
                if (exp_r.size() == 0) chk(0, "r_unexpected", m_r_data, 0);
                else begin
                    cur_r = exp_r.pop_front();
                    lat = int'(($time - cur_r.t - 5) / 10);
                    chk(lat == rd_wait() + 1, "r_latency", lat, rd_wait() + 1);
                end
            end
            if (m_r_valid) begin
                chk(m_r_data == cur_r.data, "r_data", m_r_data, cur_r.data);
                chk(m_ce_n && !m_ar_ready, "r_resp_sram_idle", {30'd0, m_ce_n, m_ar_ready}, 32'h2);
            end

            if (m_b_valid && !prev_bv) begin
                if (exp_w.size() == 0) chk(0, "b_unexpected", 1, 0);
                else begin
                    lat = int'(($time - exp_w[0].t - 5) / 10);
                    chk(lat == wr_wait() + 2, "b_latency", lat, wr_wait() + 2);
                    void'(exp_w.pop_front());
                end
            end
            if (m_b_valid)
                chk(!m_ar_ready && !m_aw_ready && !m_w_ready, "b_resp_readies",
                    {29'd0, m_ar_ready, m_aw_ready, m_w_ready}, 0);

            if (r_hs_d || b_hs_d)
                chk(m_ar_ready && m_aw_ready && m_w_ready, "idle_after_resp",
                    {29'd0, m_ar_ready, m_aw_ready, m_w_ready}, 32'h7);
            prev_rv = m_r_valid;
            prev_bv = m_b_valid;
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic wait_r(input int hold);
        int n = 0;
        bit done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            if (m_r_valid) begin
                if (n >= hold) r_ready = 1'b1;
                n++;
            end
            if (m_r_valid && r_ready) done = 1;
            @(posedge clk);
            @(negedge clk);
        end
        if (!done) chk(0, "r_timeout", 0, 1);
        r_ready = 1'b0;
    endtask

    task automatic wait_b(input int hold);
        int n = 0;
        bit done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            if (m_b_valid) begin
                if (n >= hold) b_ready = 1'b1;
                n++;
            end
            if (m_b_valid && b_ready) done = 1;
            @(posedge clk);
            @(negedge clk);
        end
        if (!done) chk(0, "b_timeout", 0, 1);
        b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [17:0] a, input int hold);
        time t = 0;
        bit ok = 0, rdy;
        r_ready  = (hold == 0);
        ar_addr  = a;
        ar_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rdy = m_ar_ready;
            @(posedge clk);
            if (rdy) begin ok = 1; t = $time; break; end
            @(negedge clk);
        end
        if (!ok) chk(0, "ar_timeout", 0, 1);
        exp_r.push_back('{ref_mem[sel][a], t});
        @(negedge clk);
        ar_valid = 1'b0;
        wait_r(hold);
    endtask

    // Returns at the posedge on which the last requested half was accepted.
    task automatic hs_wr(input bit do_aw, input bit do_w, input logic [17:0] a,
                         input logic [15:0] d, output time t_last);
        bit pa = do_aw, pw = do_w, ra, rw, ok = 0;
        aw_addr = a;
        w_data  = d;
        if (pa) aw_valid = 1'b1;
        if (pw) w_valid = 1'b1;
        t_last = 0;
        for (int i = 0; i < 40; i++) begin
            ra = m_aw_ready;
            rw = m_w_ready;
            @(posedge clk);
            if (pa && ra) begin pa = 0; t_last = $time; end
            if (pw && rw) begin pw = 0; t_last = $time; end
            if (!pa && !pw) begin ok = 1; break; end
            @(negedge clk);
            if (!pa) aw_valid = 1'b0;
            if (!pw) w_valid = 1'b0;
        end
        if (!ok) chk(0, "wr_handshake_timeout", {30'd0, pa, pw}, 0);
    endtask

    task automatic issue_write(input logic [17:0] a, input logic [15:0] d, input int mode);
        time t1, t2;
        if (mode == 0) hs_wr(1, 1, a, d, t2);
        else begin
            hs_wr(mode == 2, mode == 1, a, d, t1);
            @(negedge clk);
            aw_valid = 1'b0;
            w_valid  = 1'b0;
            chk(!m_ar_ready, "ar_ready_collect", m_ar_ready, 0);
            chk((mode == 1) ? (!m_w_ready && m_aw_ready) : (!m_aw_ready && m_w_ready),
                "half_ready_collect", {30'd0, m_aw_ready, m_w_ready}, (mode == 1) ? 32'h2 : 32'h1);
            @(negedge clk);
            hs_wr(mode == 1, mode == 2, a, d, t2);
        end
        exp_w.push_back('{a, d, t2});
        @(negedge clk);
        aw_valid = 1'b0;
        w_valid  = 1'b0;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d, input int mode, input int hold);
        b_ready = (hold == 0);
        issue_write(a, d, mode);
        ref_mem[sel][a] = d;
        wait_b(hold);
    endtask

    logic [17:0] pool [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pool = '{18'h00000, 18'h3FFFF, 18'h00001, 18'h00123, 18'h2AAAA, 18'h15555, 18'h3FFFE, 18'h00042};
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 262144; a++) begin
                mem[k][a]     = dflt(18'(a));
                ref_mem[k][a] = dflt(18'(a));
            end

        repeat (3) @(negedge clk);
        chk(!m_ar_ready && !m_aw_ready && !m_w_ready, "readies_in_reset",
            {29'd0, m_ar_ready, m_aw_ready, m_w_ready}, 0);
        chk(m_ce_n && m_oe_n && m_we_n && !m_dqoe, "ctrl_in_reset",
            {28'd0, m_ce_n, m_oe_n, m_we_n, m_dqoe}, 32'hE);
        chk(m_addr == 0 && m_dqo == 0 && m_r_data == 0 && !m_r_valid && !m_b_valid,
            "data_in_reset", {m_addr[15:0], m_r_data}, 0);
        rst_n = 1'b1;
        #1;
        chk(m_ar_ready && m_aw_ready && m_w_ready, "readies_after_reset",
            {29'd0, m_ar_ready, m_aw_ready, m_w_ready}, 32'h7);

        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            sel = s[0];
            @(negedge clk);
            mem[s][18'h00123]     = 16'hBEEF;
            ref_mem[s][18'h00123] = 16'hBEEF;
            do_read(18'h00123, 0);
            do_write(18'h3FFFF, 16'h1234, 1, 0);
            do_read(18'h3FFFF, 0);
            do_write(18'h00042, 16'hA5A5, 0, 5);
            do_read(18'h00042, 10);
            do_write(18'h00000, 16'h0F0F, 2, 1);
            do_read(18'h00000, 0);
            for (int i = 0; i < 30; i++) begin
                logic [17:0] a;
                a = pool[$urandom_range(0, 7)];
                if ($urandom_range(0, 1) == 1)
                    do_write(a, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
                else
                    do_read(a, $urandom_range(0, 3));
            end

            if (s == 0) begin
                // Abort a write in the middle of its we_n pulse.
                b_ready = 1'b0;
                issue_write(18'h0BEAD, 16'h7777, 0);
                for (int i = 0; i < 20; i++) begin
                    if (!m_we_n) break;
                    @(negedge clk);
                end
                chk(!m_we_n, "reached_we_pulse", m_we_n, 0);
                #2;
                rst_n = 1'b0;
                #1;
                chk(m_we_n && m_ce_n && m_oe_n && !m_dqoe, "reset_ctrl_immediate",
                    {28'd0, m_ce_n, m_oe_n, m_we_n, m_dqoe}, 32'hE);
                chk(!m_ar_ready && !m_aw_ready && !m_w_ready, "readies_mid_reset",
                    {29'd0, m_ar_ready, m_aw_ready, m_w_ready}, 0);
                exp_w.delete();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                #1;
                chk(m_ar_ready && m_aw_ready && m_w_ready && !m_b_valid && !m_r_valid,
                    "idle_after_abort", {28'd0, m_ar_ready, m_aw_ready, m_w_ready, m_b_valid}, 32'he);
                repeat (8) @(negedge clk);
                chk(!m_b_valid, "b_dropped_after_reset", m_b_valid, 0);
                do_read(18'h0BEAD, 0);
            end
        end

        repeat (4) @(negedge clk);
        chk(exp_r.size() == 0 && exp_w.size() == 0, "scoreboard_drained",
            exp_r.size() + exp_w.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
